// File: rtl/ap_sel_arbiter.sv
// Round-robin owner arbiter for the shared AP register-select resource.
// One owner at a time, bounded hold time, registered grant and AP select outputs.
module ap_sel_arbiter #(
    parameter int NREQ       = 4,
    parameter int AP_MAX     = 8,
    parameter int DEFAULT_AP = 0,
    parameter int HOLD_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_ap,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        ap_set,
    output logic              busy,
    output logic              timeout,
    output logic              ap_err
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD_MAX);
    localparam logic [3:0]    AP_LIM    = 4'(AP_MAX);
    localparam logic [3:0]    AP_DEF    = 4'(DEFAULT_AP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [3:0]      ap_set_q, ap_set_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic            ap_err_q, ap_err_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic [3:0]      ap_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   owner_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_ap
        assign ap_arr[g] = req_ap[4*g +: 4];
    end

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_next = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ap_set_d   = ap_set_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        ap_err_d   = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        owner_d    = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_OWN;
                    owner_d    = win_idx;
                    gnt_d      = NREQ'(1) << win_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    if (ap_arr[win_idx] > AP_LIM) begin
                        ap_set_d = AP_DEF;
                        ap_err_d = 1'b1;
                    end else begin
                        ap_set_d = ap_arr[win_idx];
                    end
                end
            end
            ST_OWN: begin
                // Voluntary release takes precedence; timeout only flags a still-requesting owner.
                if (!req[owner_q] || hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    ap_set_d  = AP_DEF;
                    busy_d    = 1'b0;
                    timeout_d = req[owner_q];
                    rr_ptr_d  = owner_next;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (ap_arr[owner_q] > AP_LIM) begin
                        ap_err_d = 1'b1;
                    end else begin
                        ap_set_d = ap_arr[owner_q];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ap_set_q   <= AP_DEF;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ap_err_q   <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ap_set_q   <= ap_set_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ap_err_q   <= ap_err_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            owner_q    <= owner_d;
        end
    end

    assign gnt     = gnt_q;
    assign ap_set  = ap_set_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign ap_err  = ap_err_q;

endmodule
